// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm duty path: default data width and the
// ramp controller state encoding.
package pwm_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_wrap_det.sv
// Period tick detector: flags the last phase count before the counter wraps.
module pwm_wrap_det #(
  parameter int DW = pwm_pkg::DW_DEF
) (
  input  logic [DW-1:0] phase_acc,
  output logic          tick
);

  assign tick = &phase_acc;

endmodule

// File: rtl/duty_ramp.sv
// Duty-cycle ramp controller: accepts a target duty over a valid/ready
// handshake and steps duty_cycle toward it once per pwm period.
module duty_ramp
  import pwm_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tgt_valid,
  output logic          tgt_ready,
  input  logic [DW-1:0] tgt_duty,
  input  logic [DW-1:0] step,
  input  logic          freeze,
  input  logic [DW-1:0] phase_acc,
  output logic [DW-1:0] duty_cycle,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [DW-1:0] tgt_q, tgt_d;
  logic [DW-1:0] step_q, step_d;
  logic          done_q, done_d;
  logic          tick;
  logic          advance;
  logic [DW-1:0] up_gap;
  logic [DW-1:0] dn_gap;

  pwm_wrap_det #(.DW(DW)) u_wrap_det (
    .phase_acc (phase_acc),
    .tick      (tick)
  );

  assign advance = tick && !freeze;
  // Gaps are only consumed in the state where they cannot underflow.
  assign up_gap  = tgt_q - duty_q;
  assign dn_gap  = duty_q - tgt_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    step_d  = step_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          tgt_d  = tgt_duty;
          step_d = (step == '0) ? DW'(1) : step;
          if (tgt_duty > duty_q)      state_d = ST_UP;
          else if (tgt_duty < duty_q) state_d = ST_DOWN;
          else                        done_d  = 1'b1;
        end
      end
      ST_UP: begin
        if (advance) begin
          if (up_gap <= step_q) begin
            duty_d  = tgt_q;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q + step_q;
          end
        end
      end
      ST_DOWN: begin
        if (advance) begin
          if (dn_gap <= step_q) begin
            duty_d  = tgt_q;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q - step_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign duty_cycle = duty_q;
  assign done       = done_q;
  assign tgt_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp with a free-running 8-bit phase counter.
module tb_duty_ramp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid;
  logic       tgt_ready;
  logic [7:0] tgt_duty;
  logic [7:0] step;
  logic       freeze;
  logic [7:0] phase_acc = 8'd0;
  logic [7:0] duty_cycle;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;
  int done_total = 0;

  duty_ramp #(.DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .tgt_duty   (tgt_duty),
    .step       (step),
    .freeze     (freeze),
    .phase_acc  (phase_acc),
    .duty_cycle (duty_cycle),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) phase_acc <= phase_acc + 8'd1;

  // Counts done pulses at the edge after they appear.
  always @(posedge clk) if (done === 1'b1) done_total++;

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns at the first negedge where the counter has just wrapped to 0.
  task automatic wait_wrap();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase_acc != 8'd0 && n < 300);
    if (phase_acc != 8'd0) begin
      tests++; fails++;
      $display("FAIL wrap_timeout: phase_acc=%0d after %0d cycles, required 0", phase_acc, n);
    end
  endtask

  // Offers a target and returns at the negedge following the transfer edge.
  task automatic send(input logic [7:0] t, input logic [7:0] s);
    int n = 0;
    tgt_valid = 1'b1;
    tgt_duty  = t;
    step      = s;
    while (tgt_ready !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (tgt_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL send_timeout: tgt_ready=%b, required 1", tgt_ready);
    end
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (duty_cycle !== 8'd0) begin fails++; $display("FAIL rst_duty: got %0d want 0", duty_cycle); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", done); end
    tests++; if (tgt_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", tgt_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_d [4] = '{8'd30, 8'd60, 8'd90, 8'd100};
    int d0;
    send(8'd100, 8'd30);
    tests++; if (busy !== 1'b1 || tgt_ready !== 1'b0) begin fails++; $display("FAIL up_start: busy=%b ready=%b want 1/0", busy, tgt_ready); end
    tests++; if (duty_cycle !== 8'd0) begin fails++; $display("FAIL up_hold0: got %0d want 0", duty_cycle); end
    d0 = done_total;
    for (int i = 0; i < 4; i++) begin
      wait_wrap();
      tests++; if (duty_cycle !== exp_d[i]) begin fails++; $display("FAIL up_step%0d: got %0d want %0d", i, duty_cycle, exp_d[i]); end
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL up_done: done=%b busy=%b want 1/0", done, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL up_done_width: got %b want 0", done); end
    tests++; if (done_total - d0 != 1) begin fails++; $display("FAIL up_done_count: got %0d want 1", done_total - d0); end
  endtask

  task automatic test_ramp_down();
    send(8'd10, 8'd0);
    for (int i = 1; i <= 90; i++) begin
      wait_wrap();
      tests++; if (duty_cycle !== 8'(100 - i)) begin fails++; $display("FAIL down_step%0d: got %0d want %0d", i, duty_cycle, 100 - i); end
    end
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL down_done: done=%b busy=%b want 1/0", done, busy); end
    wait_wrap();
    tests++; if (duty_cycle !== 8'd10) begin fails++; $display("FAIL down_hold: got %0d want 10", duty_cycle); end
  endtask

  task automatic test_equal();
    send(8'd50, 8'd40);
    wait_wrap();
    tests++; if (duty_cycle !== 8'd50) begin fails++; $display("FAIL eq_setup: got %0d want 50", duty_cycle); end
    @(negedge clk);
    send(8'd50, 8'd7);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL eq_done: got %b want 1", done); end
    tests++; if (busy !== 1'b0 || tgt_ready !== 1'b1) begin fails++; $display("FAIL eq_idle: busy=%b ready=%b want 0/1", busy, tgt_ready); end
    tests++; if (duty_cycle !== 8'd50) begin fails++; $display("FAIL eq_duty: got %0d want 50", duty_cycle); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL eq_done_width: got %b want 0", done); end
  endtask

  task automatic test_freeze();
    logic [7:0] exp_d [3] = '{8'd100, 8'd150, 8'd200};
    do_reset();
    send(8'd200, 8'd50);
    wait_wrap();
    tests++; if (duty_cycle !== 8'd50) begin fails++; $display("FAIL frz_first: got %0d want 50", duty_cycle); end
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_wrap();
      tests++; if (duty_cycle !== 8'd50 || busy !== 1'b1) begin fails++; $display("FAIL frz_hold%0d: duty=%0d busy=%b want 50/1", i, duty_cycle, busy); end
    end
    freeze = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_wrap();
      tests++; if (duty_cycle !== exp_d[i]) begin fails++; $display("FAIL frz_resume%0d: got %0d want %0d", i, duty_cycle, exp_d[i]); end
    end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL frz_done: got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [4] = '{8'd30, 8'd60, 8'd90, 8'd120};
    int d0;
    do_reset();
    send(8'd120, 8'd30);
    tgt_valid = 1'b1;
    tgt_duty  = 8'd100;
    step      = 8'd0;
    for (int i = 0; i < 4; i++) begin
      wait_wrap();
      tests++; if (duty_cycle !== exp_d[i]) begin fails++; $display("FAIL hs_step%0d: got %0d want %0d", i, duty_cycle, exp_d[i]); end
      if (i < 3) begin
        tests++; if (tgt_ready !== 1'b0) begin fails++; $display("FAIL hs_ready%0d: got %b want 0", i, tgt_ready); end
      end
    end
    tests++; if (tgt_ready !== 1'b1 || done !== 1'b1) begin fails++; $display("FAIL hs_idle: ready=%b done=%b want 1/1", tgt_ready, done); end
    @(negedge clk);
    tgt_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL hs_accept: busy=%b want 1", busy); end

    // Abort a fresh ramp at value 90.
    do_reset();
    send(8'd150, 8'd30);
    repeat (3) wait_wrap();
    tests++; if (duty_cycle !== 8'd90) begin fails++; $display("FAIL rstmid_setup: got %0d want 90", duty_cycle); end
    rst_n = 1'b0;
    d0 = done_total;
    @(negedge clk);
    tests++; if (duty_cycle !== 8'd0 || tgt_ready !== 1'b1) begin fails++; $display("FAIL rstmid_state: duty=%0d ready=%b want 0/1", duty_cycle, tgt_ready); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_flags: busy=%b done=%b want 0/0", busy, done); end
    rst_n = 1'b1;
    repeat (2) wait_wrap();
    tests++; if (duty_cycle !== 8'd0 || done_total != d0) begin fails++; $display("FAIL rstmid_after: duty=%0d dones=%0d want 0/0", duty_cycle, done_total - d0); end
  endtask

  task automatic test_boundary();
    do_reset();
    send(8'd255, 8'd255);
    wait_wrap();
    tests++; if (duty_cycle !== 8'd255 || done !== 1'b1) begin fails++; $display("FAIL bnd_max: duty=%0d done=%b want 255/1", duty_cycle, done); end
    @(negedge clk);
    send(8'd0, 8'd200);
    wait_wrap();
    tests++; if (duty_cycle !== 8'd55 || busy !== 1'b1) begin fails++; $display("FAIL bnd_mid: duty=%0d busy=%b want 55/1", duty_cycle, busy); end
    wait_wrap();
    tests++; if (duty_cycle !== 8'd0 || done !== 1'b1) begin fails++; $display("FAIL bnd_zero: duty=%0d done=%b want 0/1", duty_cycle, done); end
  endtask

  initial begin
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_duty  = 8'd0;
    step      = 8'd0;
    freeze    = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_equal();
    test_freeze();
    test_back_to_back();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 Parameter DW, default 8, width of duty, step and phase values.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tgt_valid  input  1  new target duty offered.
REQ-005 tgt_ready  output  1  block can accept a new target.
REQ-006 tgt_duty  input  DW  requested final duty value.
REQ-007 step  input  DW  per-period increment, captured with tgt_duty.
REQ-008 freeze  input  1  when high, ramp progress halts and duty_cycle holds.
REQ-009 phase_acc  input  DW  phase counter from the downstream pwm stage.
REQ-010 duty_cycle  output  DW  registered duty driving the pwm stage.
REQ-011 busy  output  1  high while ramping (state UP or DOWN).
REQ-012 done  output  1  one-cycle pulse when duty_cycle reaches the target.

Function
REQ-013 The block SHALL have states IDLE, UP and DOWN, all registered.
REQ-014 tgt_ready SHALL be high only in IDLE; a transfer occurs when tgt_valid and tgt_ready are both high on a rising edge.
REQ-015 On transfer, the block SHALL capture tgt_duty into tgt_q and step into step_q, with step 0 stored as 1.
REQ-016 On transfer, the next state SHALL be UP if tgt_duty > duty_cycle, DOWN if tgt_duty < duty_cycle, or IDLE if equal.
REQ-017 An equal-value transfer SHALL pulse done in the following cycle.
REQ-018 A period tick SHALL be asserted when phase_acc equals all-ones, which is the last count before wrap.
REQ-019 In UP, on a tick with freeze low, duty_cycle SHALL become tgt_q if (tgt_q - duty_cycle) <= step_q, else duty_cycle + step_q.
REQ-020 In DOWN, on a tick with freeze low, duty_cycle SHALL become tgt_q if (duty_cycle - tgt_q) <= step_q, else duty_cycle - step_q.
REQ-021 Arithmetic SHALL be unsigned DW-bit, so duty_cycle never overshoots tgt_q and never wraps.
REQ-022 duty_cycle SHALL update in the tick cycle, so the new value is present when phase_acc reads 0.
REQ-023 When the update makes duty_cycle equal tgt_q, the state SHALL return to IDLE and done SHALL pulse for exactly one cycle, in the cycle after the final update.
REQ-024 duty_cycle SHALL change only on a tick in UP or DOWN; outside those, it holds its value.
REQ-025 freeze SHALL NOT block handshake acceptance in IDLE.
REQ-026 Ticks arriving while freeze is high SHALL be dropped, not queued.
REQ-027 tgt_valid SHALL be ignored while busy; the upstream holds its request until tgt_ready.
REQ-028 busy SHALL equal (state != IDLE); tgt_ready SHALL equal (state == IDLE).

Reset
REQ-029 While rst_n is low at a rising edge, the state SHALL go to IDLE and duty_cycle, tgt_q, step_q, busy and done SHALL go to 0.
REQ-030 After such a reset, tgt_ready SHALL be 1.
REQ-031 Reset mid-ramp SHALL abort the ramp with no done pulse.
REQ-032 Reset SHALL have no asynchronous path.

Structure
REQ-033 A shared package pwm_pkg SHALL hold the DW default and the state encoding (IDLE=0, UP=1, DOWN=2).
REQ-034 The tick detector SHALL be a sub-module pwm_wrap_det: input phase_acc, combinational output tick, parameter DW.
REQ-035 The remainder SHALL be one registered FSM and datapath in duty_ramp.

Verification (DW=8, phase_acc driven by a free-running 8-bit counter)
REQ-036 Ramp up: from duty 0, target 100 with step 30 -> duty_cycle goes 30, 60, 90, 100 on four successive wraps; done pulses once; busy drops.
REQ-037 Ramp down: from duty 100, target 10 with step 0 -> duty_cycle decrements by 1 per wrap, reaching 10 after 90 wraps with no undershoot.
REQ-038 Equal target: at duty 50, target 50 -> state stays IDLE, done pulses next cycle, duty_cycle unchanged.
REQ-039 Freeze: ramp 0 to 200 with step 50, freeze high across two wraps after the value 50 -> duty_cycle holds 50 through both, then resumes 100, 150, 200.
REQ-040 Handshake and reset: tgt_valid held while busy -> not accepted until IDLE; rst_n low at value 90 of a ramp -> next cycle duty_cycle=0, tgt_ready=1, no done pulse.
REQ-041 Boundary: target 255 with step 255 from 0 -> one wrap gives 255; then target 0 with step 200 -> 55, then 0.
